mips_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the MIPS decode/execute core. It generates sequential word-aligned fetch addresses to instruction memory and tracks in-flight requests. Returned words are buffered in a small prefetch FIFO and presented to the core as {instruction, pc} over a valid/ready interface. Redirect (branch/jump) requests flush the buffer and discard stale in-flight responses.

---
 rtl/mips_fetch_unit_if.sv | 39 +++
 rtl/mips_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_mips_fetch_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_fetch_unit_if.sv
// Bundle of every handshake and bus signal around the fetch stage.
// master: the fetch unit. It drives the instruction-memory requests and the
//         instruction stream to the core.
// slave:  the surroundings. This is the core, which issues redirects and
//         consumes instructions, plus the instruction memory.
// Signals:
//   redirect_valid/redirect_pc   core -> fetch: restart the stream at redirect_pc
//   imem_req_valid/ready/addr    fetch -> memory: word fetch request
//   imem_rsp_valid/data          memory -> fetch: in-order response, always accepted
//   inst_valid/ready/data/pc     fetch -> core: {instruction, pc} stream
interface mips_fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_ready,
    output imem_req_valid, imem_req_addr,
    output inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_ready,
    input  imem_req_valid, imem_req_addr,
    input  inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// MIPS instruction fetch stage.
// The unit issues sequential word-aligned fetch requests to instruction memory.
// It buffers the returned words in a prefetch FIFO and hands them to the core
// as {instruction, pc}. A redirect flushes the buffer and moves the fetch
// stream to a new target. Responses that are still in flight at that point are
// counted and dropped when they arrive.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  mips_fetch_unit_if.master (redirect, imem request/response, inst stream)
// Parameters:
//   RESET_PC    first fetch address after reset (low two bits forced to 0)
//   FIFO_DEPTH  prefetch entries (power of 2, >= 2); also caps in-flight + buffered
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  mips_fetch_unit_if.master         bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;
  localparam logic [CNT_W:0]   CREDIT_LIMIT = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT    = CNT_W'(FIFO_DEPTH);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PTR_W-1:0] ptr_t;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  cnt_t        count_q, count_d;
  cnt_t        outstanding_q, outstanding_d;
  cnt_t        discard_cnt_q, discard_cnt_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  logic [31:0] fifo_data_q [FIFO_DEPTH];
  logic [31:0] fifo_data_d [FIFO_DEPTH];
  logic [31:0] fifo_pc_q   [FIFO_DEPTH];
  logic [31:0] fifo_pc_d   [FIFO_DEPTH];

  logic [CNT_W:0] credit_used;
  logic [31:0]    redirect_target;
  logic           req_valid;
  logic           issue;
  logic           out_valid;
  logic           push;
  logic           pop;

  // Outstanding requests include those already marked for discard. Stale
  // responses would otherwise be able to land on top of a full FIFO.
  assign credit_used     = {1'b0, count_q} + {1'b0, outstanding_q};
  assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;
  assign req_valid       = !rst && !bus.redirect_valid && (credit_used < CREDIT_LIMIT);
  assign issue           = req_valid && bus.imem_req_ready;
  assign out_valid       = !rst && (count_q != '0) && !bus.redirect_valid;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.inst_valid     = out_valid;
  assign bus.inst_data      = fifo_data_q[rd_ptr_q];
  assign bus.inst_pc        = fifo_pc_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_cnt_d = discard_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_data_d   = fifo_data_q;
    fifo_pc_d     = fifo_pc_q;
    push          = 1'b0;
    pop           = 1'b0;

    if (bus.redirect_valid) begin
      // A redirect overrides everything else. Every request still in flight
      // after this cycle belongs to the old stream and must be dropped.
      fetch_pc_d    = redirect_target;
      rsp_pc_d      = redirect_target;
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      outstanding_d = outstanding_q - cnt_t'(bus.imem_rsp_valid);
      discard_cnt_d = outstanding_d;
    end else begin
      pop = out_valid && bus.inst_ready;

      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end

      if (bus.imem_rsp_valid) begin
        if (discard_cnt_q != '0) begin
          discard_cnt_d = discard_cnt_q - cnt_t'(1);
        end else begin
          push = 1'b1;
        end
      end

      outstanding_d = outstanding_q + cnt_t'(issue) - cnt_t'(bus.imem_rsp_valid);

      if (push) begin
        fifo_data_d[wr_ptr_q] = bus.imem_rsp_data;
        fifo_pc_d[wr_ptr_q]   = rsp_pc_q;
        wr_ptr_d              = wr_ptr_q + ptr_t'(1);
        rsp_pc_d              = rsp_pc_q + 32'd4;
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end

      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC_ALIGNED;
      rsp_pc_q      <= RESET_PC_ALIGNED;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_cnt_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_cnt_q <= discard_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Storage needs no reset. Entries are only ever read when count_q says
  // they hold valid data.
  always_ff @(posedge clk) begin
    fifo_data_q <= fifo_data_d;
    fifo_pc_q   <= fifo_pc_d;
  end

  // Credit accounting must never let a kept response find the FIFO full.
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == DEPTH_CNT)));

  // Memory must not return more words than were requested.
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
    !(bus.imem_rsp_valid && (outstanding_q == '0)));

  a_counter_bounds: assert property (@(posedge clk) disable iff (rst)
    (outstanding_q <= DEPTH_CNT) && (discard_cnt_q <= outstanding_q));

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed testbench for mips_fetch_unit.
// The bench contains a small in-order instruction memory model. It holds a
// queue of accepted request addresses and returns one word per cycle unless
// mem_hold is set. Each returned word is address ^ 32'h1234_5678, so the
// expected instruction words below are written out by hand.
module tb_mips_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  logic mem_hold;
  logic [31:0] pend [$];
  int checks = 0;
  int errors = 0;
  int req_count = 0;

  always #5 clk = ~clk;

  mips_fetch_unit_if bus();

  mips_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Drive every core/memory input for the coming cycle, then let the
  // combinational outputs settle before anything is sampled.
  task automatic applyStimulus(input logic r, input logic redir, input logic [31:0] rpc,
                               input logic req_rdy, input logic i_rdy, input logic hold);
    rst                = r;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.imem_req_ready = req_rdy;
    bus.inst_ready     = i_rdy;
    mem_hold           = hold;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one clock. Memory presents its head response for this cycle, the
  // request handshake is sampled mid-cycle, and the pending queue is updated
  // after the edge.
  task automatic step();
    logic        acc;
    logic [31:0] acc_addr;
    logic        rsp_taken;
    if (!rst && !mem_hold && (pend.size() > 0)) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = pend[0] ^ 32'h1234_5678;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end
    @(negedge clk);
    acc       = bus.imem_req_valid && bus.imem_req_ready;
    acc_addr  = bus.imem_req_addr;
    rsp_taken = bus.imem_rsp_valid;
    @(posedge clk);
    #1;
    if (rst) begin
      pend.delete();
    end else begin
      if (rsp_taken) void'(pend.pop_front());
      if (acc) begin
        pend.push_back(acc_addr);
        req_count++;
      end
    end
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    step();
    step();
  endtask

  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;

    // Streaming fetch with single-cycle memory latency.
    $display("[TB] streaming fetch");
    resetDut();
    checkBit("rst_req_valid", bus.imem_req_valid, 1'b0);
    checkBit("rst_inst_valid", bus.inst_valid, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkBit("t1_req_valid", bus.imem_req_valid, 1'b1);
    checkOutput("t1_addr0", bus.imem_req_addr, 32'h0);
    step();
    checkOutput("t1_addr1", bus.imem_req_addr, 32'h4);
    checkBit("t1_no_inst_yet", bus.inst_valid, 1'b0);
    step();
    checkOutput("t1_addr2", bus.imem_req_addr, 32'h8);
    checkBit("t1_inst_valid0", bus.inst_valid, 1'b1);
    checkOutput("t1_pc0", bus.inst_pc, 32'h0);
    checkOutput("t1_data0", bus.inst_data, 32'h1234_5678);
    step();
    checkOutput("t1_pc1", bus.inst_pc, 32'h4);
    checkOutput("t1_data1", bus.inst_data, 32'h1234_567C);
    step();
    checkBit("t1_inst_valid2", bus.inst_valid, 1'b1);
    checkOutput("t1_pc2", bus.inst_pc, 32'h8);
    checkOutput("t1_data2", bus.inst_data, 32'h1234_5670);
    step();

    // Core stalled: fetch stops once all credits are used, then resumes.
    $display("[TB] credit limit with stalled core");
    resetDut();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    req_count = 0;
    repeat (8) step();
    checkOutput("t2_req_count", 32'(req_count), 32'd4);
    checkBit("t2_req_valid_full", bus.imem_req_valid, 1'b0);
    checkOutput("t2_count_full", 32'(dut.count_q), 32'd4);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkBit("t2_inst_valid", bus.inst_valid, 1'b1);
    checkOutput("t2_pc0", bus.inst_pc, 32'h0);
    checkOutput("t2_data0", bus.inst_data, 32'h1234_5678);
    step();
    checkOutput("t2_pc1", bus.inst_pc, 32'h4);
    checkBit("t2_resume_valid", bus.imem_req_valid, 1'b1);
    checkOutput("t2_resume_addr", bus.imem_req_addr, 32'h10);
    step();
    checkOutput("t2_pc2", bus.inst_pc, 32'h8);
    step();
    checkOutput("t2_pc3", bus.inst_pc, 32'hC);
    checkOutput("t2_data3", bus.inst_data, 32'h1234_5674);
    step();

    // Redirect with three requests in flight and no responses yet.
    $display("[TB] redirect with three in flight");
    resetDut();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    repeat (3) step();
    checkOutput("t3_outstanding", 32'(dut.outstanding_q), 32'd3);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1);
    checkBit("t3_redir_req_valid", bus.imem_req_valid, 1'b0);
    checkBit("t3_redir_inst_valid", bus.inst_valid, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("t3_discard", 32'(dut.discard_cnt_q), 32'd3);
    checkOutput("t3_new_addr", bus.imem_req_addr, 32'h100);
    step();
    checkBit("t3_drop1", bus.inst_valid, 1'b0);
    step();
    checkBit("t3_drop2", bus.inst_valid, 1'b0);
    step();
    checkBit("t3_drop3", bus.inst_valid, 1'b0);
    step();
    checkBit("t3_first_valid", bus.inst_valid, 1'b1);
    checkOutput("t3_first_pc", bus.inst_pc, 32'h100);
    checkOutput("t3_first_data", bus.inst_data, 32'h1234_5778);
    step();

    // Redirect coinciding with a response while the FIFO holds two entries.
    $display("[TB] redirect with response and buffered entries");
    resetDut();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    step();
    checkOutput("t4_count_before", 32'(dut.count_q), 32'd2);
    checkOutput("t4_out_before", 32'(dut.outstanding_q), 32'd2);
    applyStimulus(1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 1'b0);
    checkBit("t4_redir_inst_valid", bus.inst_valid, 1'b0);
    checkBit("t4_redir_req_valid", bus.imem_req_valid, 1'b0);
    step();
    checkOutput("t4_count_after", 32'(dut.count_q), 32'd0);
    checkOutput("t4_discard_after", 32'(dut.discard_cnt_q), 32'd1);
    checkOutput("t4_out_after", 32'(dut.outstanding_q), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("t4_new_addr", bus.imem_req_addr, 32'h200);
    checkBit("t4_flushed", bus.inst_valid, 1'b0);
    step();
    checkBit("t4_stale_dropped", bus.inst_valid, 1'b0);
    step();
    checkBit("t4_first_valid", bus.inst_valid, 1'b1);
    checkOutput("t4_first_pc", bus.inst_pc, 32'h200);
    checkOutput("t4_first_data", bus.inst_data, 32'h1234_5478);
    step();

    // Memory back-pressure keeps the pending request stable.
    $display("[TB] request stall");
    resetDut();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step();
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkBit("t5_stall_valid", bus.imem_req_valid, 1'b1);
      checkOutput("t5_stall_addr", bus.imem_req_addr, 32'h8);
      step();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_accept_addr", bus.imem_req_addr, 32'h8);
    step();
    checkOutput("t5_next_addr", bus.imem_req_addr, 32'hC);
    step();

    // Unaligned redirect target, then reset in the middle of the stream.
    $display("[TB] unaligned redirect and mid-stream reset");
    applyStimulus(1'b0, 1'b1, 32'h103, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_aligned_addr", bus.imem_req_addr, 32'h100);
    step();
    step();
    step();
    checkBit("t6_buffered_valid", bus.inst_valid, 1'b1);
    checkOutput("t6_buffered_pc", bus.inst_pc, 32'h100);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkBit("t6_rst_req_valid", bus.imem_req_valid, 1'b0);
    checkBit("t6_rst_inst_valid", bus.inst_valid, 1'b0);
    step();
    checkBit("t6_rst_req_valid2", bus.imem_req_valid, 1'b0);
    checkBit("t6_rst_inst_valid2", bus.inst_valid, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkBit("t6_post_req_valid", bus.imem_req_valid, 1'b1);
    checkOutput("t6_post_addr", bus.imem_req_addr, 32'h0);
    checkBit("t6_post_inst_valid", bus.inst_valid, 1'b0);
    checkOutput("t6_post_count", 32'(dut.count_q), 32'd0);
    step();
    step();
    checkOutput("t6_post_pc", bus.inst_pc, 32'h0);
    checkOutput("t6_post_data", bus.inst_data, 32'h1234_5678);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
